ps2_id_entry: RTL and testbench
===============================

Name: ps2_id_entry

Overview:
- Upstream stage of the parking controller. Turns raw keyboard events (key1_code / key1_on) into the controller's key stream and ID buffer.
- Detects new key presses and decodes PS/2 set-2 digit make codes to BCD.
- Shifts digits into a 7-digit ID buffer, raises buffer_full, and flags the ESC and Ctrl+A command keys.

Parameters:
- NUM_DIGITS, 7, number of BCD digits in the ID buffer.
- ID_W, 4*NUM_DIGITS, width of the ID output (28 by default).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous buffer clear, active-high; driven by the controller between entries.
- key1_code  in  8  PS/2 set-2 make code of the current key.
- key1_on  in  1  level; high while key1_code is held.
- key_pressed  out  1  one-cycle pulse per accepted key event.
- key  out  4  BCD value of the last accepted digit; held until the next digit.
- ID  out  ID_W  entered digits; first-entered digit in the MS nibble after a full entry.
- buffer_full  out  1  level; high when NUM_DIGITS digits are held.
- esc_pressed  out  1  one-cycle pulse, coincident with key_pressed.
- ctrla_pressed  out  1  one-cycle pulse, coincident with key_pressed.

Behaviour:
- Reset (async, reset=0) clears everything to 0: outputs, digit count, ctrl_armed, key1_on_d.
- Event detect:
  - ev = key1_on & ~key1_on_d, where key1_on_d is a 1-cycle register.
  - Code is sampled in the ev cycle. Holding a key generates no repeats.
- Decode:
  - Digit map: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - ESC=76, CTRL=14, A=1C. All other codes are ignored: no key_pressed, state unchanged.
- Latency: outputs are registered and update in the cycle after ev.
- FSM (2-bit state):
  - EMPTY (count=0):
    - Digit → shift in, count=1, go to COLLECT.
    - ESC / Ctrl+A → command pulse, stay in EMPTY.
  - COLLECT (1..NUM_DIGITS-1):
    - Digit → ID <= {ID[ID_W-5:0], digit}, count+1, key <= digit, key_pressed=1.
    - When count reaches NUM_DIGITS → go to FULL, with buffer_full=1 in the same cycle as the final key_pressed.
  - FULL:
    - Digits are dropped: no key_pressed, ID frozen.
    - ESC / Ctrl+A are still reported.
    - Only clr or reset leaves FULL.
- Ctrl handling:
  - A CTRL event sets ctrl_armed and produces no key_pressed.
  - The next accepted event clears ctrl_armed.
  - If that event is A → key_pressed=1, ctrla_pressed=1.
  - If it is another code → it is processed normally.
  - Standalone A (not armed) is ignored.
- ESC:
  - key_pressed=1, esc_pressed=1, clears ctrl_armed.
  - ID and count are unaffected.
- clr:
  - Next cycle: ID=0, count=0, buffer_full=0, ctrl_armed=0, state=EMPTY.
  - key is held.
  - clr in the same cycle as ev: clr wins and the event is dropped, no pulse.
  - key1_on_d still updates, so a held key is not replayed after clr.
- Reset mid-entry: all state is lost; an ID in progress is discarded.
- Count width is $clog2(NUM_DIGITS+1) and never wraps; it saturates at NUM_DIGITS.

Optional Feature:
- Macro PS2_ID_BACKSPACE_EN.
- Defined:
  - Code 66 (backspace) in COLLECT or FULL: ID <= {4'h0, ID[ID_W-1:4]}, count-1, buffer_full=0, key_pressed=1, key unchanged.
  - FULL → COLLECT; count 1 → EMPTY.
  - Backspace in EMPTY is ignored (no pulse).
- Undefined: 66 is treated as an unknown code and ignored.

Decomposition:
- Shared package ps2_pkg:
  - Scan-code localparams: digit codes, ESC, CTRL, A, BKSP.
  - State enum {EMPTY, COLLECT, FULL}.
  - Default NUM_DIGITS.
- One natural sub-module: ps2_digit_decode. Combinational code → {is_digit, bcd[3:0]}; the parking controller's keypad paths can reuse it.

Test Plan:
- Keys 2,0,2,3,0,1,5, each held 3 cycles → 7 key_pressed pulses; ID=28'h2023015, buffer_full=1 with the 7th pulse.
- ID full, then digit 7 → no key_pressed, ID stays 28'h2023015. Then ESC → key_pressed=1 and esc_pressed=1 for exactly 1 cycle.
- CTRL then A → single key_pressed with ctrla_pressed=1. Standalone A → no pulse. CTRL, then 5, then A → digit 5 accepted, A ignored.
- Digits 1,2 entered; clr asserted in the same cycle as a key1_on rise of 3 → ID=0, count=0, no pulse. Holding key 3 afterwards produces nothing.
- Reset asserted mid-entry after 4 digits → all outputs 0 immediately (async), with no clk edge required.
- With PS2_ID_BACKSPACE_EN: 7 digits, backspace → buffer_full=0, ID=28'h0202301. Then 9 → ID=28'h2023019, buffer_full=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan codes, ID-entry state encoding and default buffer depth.
package ps2_pkg;

    localparam int unsigned NUM_DIGITS_DEF = 7;

    localparam logic [7:0] CODE_0    = 8'h45;
    localparam logic [7:0] CODE_1    = 8'h16;
    localparam logic [7:0] CODE_2    = 8'h1E;
    localparam logic [7:0] CODE_3    = 8'h26;
    localparam logic [7:0] CODE_4    = 8'h25;
    localparam logic [7:0] CODE_5    = 8'h2E;
    localparam logic [7:0] CODE_6    = 8'h36;
    localparam logic [7:0] CODE_7    = 8'h3D;
    localparam logic [7:0] CODE_8    = 8'h3E;
    localparam logic [7:0] CODE_9    = 8'h46;
    localparam logic [7:0] CODE_ESC  = 8'h76;
    localparam logic [7:0] CODE_CTRL = 8'h14;
    localparam logic [7:0] CODE_A    = 8'h1C;
    localparam logic [7:0] CODE_BKSP = 8'h66;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/ps2_digit_decode.sv
// Combinational PS/2 set-2 digit make code to BCD decoder.
module ps2_digit_decode
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_digit,
    output logic [3:0] bcd
);

    always_comb begin
        is_digit = 1'b1;
        bcd      = 4'd0;
        case (code)
            CODE_0:  bcd = 4'd0;
            CODE_1:  bcd = 4'd1;
            CODE_2:  bcd = 4'd2;
            CODE_3:  bcd = 4'd3;
            CODE_4:  bcd = 4'd4;
            CODE_5:  bcd = 4'd5;
            CODE_6:  bcd = 4'd6;
            CODE_7:  bcd = 4'd7;
            CODE_8:  bcd = 4'd8;
            CODE_9:  bcd = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_id_entry.sv
// Keyboard event to ID-buffer front end. Backspace support is enabled by
// defining PS2_ID_BACKSPACE_EN; without it code 66 is ignored like any unknown code.
module ps2_id_entry
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int unsigned ID_W       = 4 * NUM_DIGITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic [7:0]      key1_code,
    input  logic            key1_on,
    output logic            key_pressed,
    output logic [3:0]      key,
    output logic [ID_W-1:0] ID,
    output logic            buffer_full,
    output logic            esc_pressed,
    output logic            ctrla_pressed
);

    localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             ctrl_armed;
    logic             key1_on_d;
    logic             ev;
    logic             is_digit;
    logic [3:0]       bcd;

    assign ev = key1_on & ~key1_on_d;

    ps2_digit_decode u_dec (
        .code     (key1_code),
        .is_digit (is_digit),
        .bcd      (bcd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= EMPTY;
            count         <= '0;
            ctrl_armed    <= 1'b0;
            key1_on_d     <= 1'b0;
            key_pressed   <= 1'b0;
            key           <= 4'd0;
            ID            <= '0;
            buffer_full   <= 1'b0;
            esc_pressed   <= 1'b0;
            ctrla_pressed <= 1'b0;
        end else begin
            // Edge tracking runs even under clr so a held key is not replayed.
            key1_on_d     <= key1_on;
            key_pressed   <= 1'b0;
            esc_pressed   <= 1'b0;
            ctrla_pressed <= 1'b0;
            if (clr) begin
                state       <= EMPTY;
                count       <= '0;
                ctrl_armed  <= 1'b0;
                ID          <= '0;
                buffer_full <= 1'b0;
            end else if (ev) begin
                if (is_digit) begin
                    ctrl_armed <= 1'b0;
                    if (state != FULL) begin
                        ID          <= {ID[ID_W-5:0], bcd};
                        count       <= count + CNT_ONE;
                        key         <= bcd;
                        key_pressed <= 1'b1;
                        if (count == CNT_LAST) begin
                            state       <= FULL;
                            buffer_full <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end else if (key1_code == CODE_ESC) begin
                    ctrl_armed  <= 1'b0;
                    key_pressed <= 1'b1;
                    esc_pressed <= 1'b1;
                end else if (key1_code == CODE_CTRL) begin
                    ctrl_armed <= 1'b1;
                end else if (key1_code == CODE_A) begin
                    // A only means something as the second half of Ctrl+A.
                    if (ctrl_armed) begin
                        key_pressed   <= 1'b1;
                        ctrla_pressed <= 1'b1;
                    end
                    ctrl_armed <= 1'b0;
`ifdef PS2_ID_BACKSPACE_EN
                end else if (key1_code == CODE_BKSP) begin
                    ctrl_armed <= 1'b0;
                    if (state != EMPTY) begin
                        ID          <= {4'h0, ID[ID_W-1:4]};
                        count       <= count - CNT_ONE;
                        buffer_full <= 1'b0;
                        key_pressed <= 1'b1;
                        state       <= (count == CNT_ONE) ? EMPTY : COLLECT;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_id_entry.sv
// Directed self-checking bench for ps2_id_entry (honours PS2_ID_BACKSPACE_EN).
module tb_ps2_id_entry;
    import ps2_pkg::*;

    logic        clk;
    logic        reset;
    logic        clr;
    logic [7:0]  key1_code;
    logic        key1_on;
    logic        key_pressed;
    logic [3:0]  key;
    logic [27:0] ID;
    logic        buffer_full;
    logic        esc_pressed;
    logic        ctrla_pressed;

    int vectors;
    int miscompares;

    ps2_id_entry dut (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .key1_code     (key1_code),
        .key1_on       (key1_on),
        .key_pressed   (key_pressed),
        .key           (key),
        .ID            (ID),
        .buffer_full   (buffer_full),
        .esc_pressed   (esc_pressed),
        .ctrla_pressed (ctrla_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold a key for 'hold' cycles, release, and tally every pulse seen.
    task automatic press(input logic [7:0] code, input int hold,
                         output int pulses, output int escs, output int ctrlas);
        pulses = 0; escs = 0; ctrlas = 0;
        @(negedge clk);
        key1_code = code;
        key1_on   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            pulses += int'(key_pressed);
            escs   += int'(esc_pressed);
            ctrlas += int'(ctrla_pressed);
        end
        key1_on = 1'b0;
        @(negedge clk);
        pulses += int'(key_pressed);
        escs   += int'(esc_pressed);
        ctrlas += int'(ctrla_pressed);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; key1_code = 8'h00; key1_on = 1'b0; reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        vectors++;
        if ({key_pressed, key, ID, buffer_full, esc_pressed, ctrla_pressed} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_state: got kp=%b key=%h ID=%h full=%b esc=%b ca=%b, want all 0",
                     key_pressed, key, ID, buffer_full, esc_pressed, ctrla_pressed);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_entry();
        logic [7:0] codes [7];
        logic [3:0] digs  [7];
        int p, e, c;
        codes = '{CODE_2, CODE_0, CODE_2, CODE_3, CODE_0, CODE_1, CODE_5};
        digs  = '{4'd2, 4'd0, 4'd2, 4'd3, 4'd0, 4'd1, 4'd5};
        for (int i = 0; i < 6; i++) begin
            press(codes[i], 3, p, e, c);
            vectors++;
            if (p !== 1 || key !== digs[i] || buffer_full !== 1'b0) begin
                miscompares++;
                $display("FAIL entry_digit%0d: got pulses=%0d key=%h full=%b, want 1 %h 0",
                         i, p, key, buffer_full, digs[i]);
            end
        end
        @(negedge clk);
        key1_code = codes[6];
        key1_on   = 1'b1;
        @(negedge clk);
        vectors++;
        if (key_pressed !== 1'b1 || buffer_full !== 1'b1 || ID !== 28'h2023015) begin
            miscompares++;
            $display("FAIL entry_last: got kp=%b full=%b ID=%h, want 1 1 2023015",
                     key_pressed, buffer_full, ID);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (key_pressed !== 1'b0 || key !== 4'd5) begin
            miscompares++;
            $display("FAIL entry_no_repeat: got kp=%b key=%h, want 0 5", key_pressed, key);
        end
        key1_on = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_drop();
        int p, e, c;
        press(CODE_7, 3, p, e, c);
        vectors++;
        if (p !== 0 || ID !== 28'h2023015 || key !== 4'd5 || buffer_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drop: got pulses=%0d ID=%h key=%h full=%b, want 0 2023015 5 1",
                     p, ID, key, buffer_full);
        end
        @(negedge clk);
        key1_code = CODE_ESC;
        key1_on   = 1'b1;
        @(negedge clk);
        vectors++;
        if (key_pressed !== 1'b1 || esc_pressed !== 1'b1 || ctrla_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL esc_pulse: got kp=%b esc=%b ca=%b, want 1 1 0",
                     key_pressed, esc_pressed, ctrla_pressed);
        end
        @(negedge clk);
        vectors++;
        if (key_pressed !== 1'b0 || esc_pressed !== 1'b0 || ID !== 28'h2023015) begin
            miscompares++;
            $display("FAIL esc_one_cycle: got kp=%b esc=%b ID=%h, want 0 0 2023015",
                     key_pressed, esc_pressed, ID);
        end
        key1_on = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backspace();
        int p, e, c;
        press(CODE_BKSP, 2, p, e, c);
`ifdef PS2_ID_BACKSPACE_EN
        vectors++;
        if (p !== 1 || buffer_full !== 1'b0 || ID !== 28'h0202301 || key !== 4'd5) begin
            miscompares++;
            $display("FAIL bksp: got pulses=%0d full=%b ID=%h key=%h, want 1 0 0202301 5",
                     p, buffer_full, ID, key);
        end
        press(CODE_9, 2, p, e, c);
        vectors++;
        if (p !== 1 || buffer_full !== 1'b1 || ID !== 28'h2023019 || key !== 4'd9) begin
            miscompares++;
            $display("FAIL bksp_refill: got pulses=%0d full=%b ID=%h key=%h, want 1 1 2023019 9",
                     p, buffer_full, ID, key);
        end
`else
        vectors++;
        if (p !== 0 || buffer_full !== 1'b1 || ID !== 28'h2023015) begin
            miscompares++;
            $display("FAIL bksp_ignored: got pulses=%0d full=%b ID=%h, want 0 1 2023015",
                     p, buffer_full, ID);
        end
`endif
    endtask

    task automatic test_ctrl();
        int p, e, c;
        do_clr();
        press(CODE_CTRL, 2, p, e, c);
        vectors++;
        if (p !== 0) begin
            miscompares++;
            $display("FAIL ctrl_silent: got pulses=%0d, want 0", p);
        end
        press(CODE_A, 2, p, e, c);
        vectors++;
        if (p !== 1 || c !== 1 || e !== 0) begin
            miscompares++;
            $display("FAIL ctrla: got pulses=%0d ctrla=%0d esc=%0d, want 1 1 0", p, c, e);
        end
        press(CODE_A, 2, p, e, c);
        vectors++;
        if (p !== 0 || c !== 0) begin
            miscompares++;
            $display("FAIL lone_a: got pulses=%0d ctrla=%0d, want 0 0", p, c);
        end
        press(CODE_CTRL, 2, p, e, c);
        press(CODE_5, 2, p, e, c);
        vectors++;
        if (p !== 1 || key !== 4'd5 || ID !== 28'h0000005) begin
            miscompares++;
            $display("FAIL ctrl_digit: got pulses=%0d key=%h ID=%h, want 1 5 0000005", p, key, ID);
        end
        press(CODE_A, 2, p, e, c);
        vectors++;
        if (p !== 0 || c !== 0) begin
            miscompares++;
            $display("FAIL ctrl_disarmed: got pulses=%0d ctrla=%0d, want 0 0", p, c);
        end
    endtask

    task automatic test_clr_collision();
        int p, e, c;
        int seen;
        do_clr();
        press(CODE_1, 2, p, e, c);
        press(CODE_2, 2, p, e, c);
        @(negedge clk);
        clr       = 1'b1;
        key1_code = CODE_3;
        key1_on   = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if (key_pressed !== 1'b0 || ID !== 28'h0 || buffer_full !== 1'b0 || key !== 4'd2) begin
            miscompares++;
            $display("FAIL clr_wins: got kp=%b ID=%h full=%b key=%h, want 0 0 0 2",
                     key_pressed, ID, buffer_full, key);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(key_pressed);
        end
        key1_on = 1'b0;
        vectors++;
        if (seen !== 0 || ID !== 28'h0) begin
            miscompares++;
            $display("FAIL clr_held_key: got pulses=%0d ID=%h, want 0 0", seen, ID);
        end
        press(CODE_4, 2, p, e, c);
        vectors++;
        if (p !== 1 || ID !== 28'h0000004) begin
            miscompares++;
            $display("FAIL clr_count: got pulses=%0d ID=%h, want 1 0000004", p, ID);
        end
    endtask

    task automatic test_reset_mid();
        int p, e, c;
        do_clr();
        press(CODE_9, 2, p, e, c);
        press(CODE_8, 2, p, e, c);
        press(CODE_7, 2, p, e, c);
        press(CODE_6, 2, p, e, c);
        vectors++;
        if (ID !== 28'h0009876 || key !== 4'd6) begin
            miscompares++;
            $display("FAIL pre_reset: got ID=%h key=%h, want 0009876 6", ID, key);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({key_pressed, key, ID, buffer_full, esc_pressed, ctrla_pressed} !== 35'd0) begin
            miscompares++;
            $display("FAIL async_reset: got kp=%b key=%h ID=%h full=%b, want all 0",
                     key_pressed, key, ID, buffer_full);
        end
        @(negedge clk);
        reset = 1'b1;
        press(CODE_3, 2, p, e, c);
        vectors++;
        if (p !== 1 || ID !== 28'h0000003) begin
            miscompares++;
            $display("FAIL post_reset: got pulses=%0d ID=%h, want 1 0000003", p, ID);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_entry();
        test_full_drop();
        test_backspace();
        test_ctrl();
        test_clr_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
